// File: rtl/shift_storage_reg_pkg.sv
// shift_reg_pkg: MODE encodings and counter-width helper shared by
// the shift/storage register, its bit counter and its bus interface.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Bits needed to hold a count of 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_storage_reg_if.sv
// shift_storage_reg_if: control/data bus of the shift/storage register.
// master drives OEn/CLRn/SE/LE/MODE/SER_L/SER_H/D and observes
// Q/QH/QA/CNT/FULL/LATCHED; slave is the register side.
interface shift_storage_reg_if #(
  parameter  int WIDTH = 8,
  localparam int CW    = shift_reg_pkg::cnt_width(WIDTH)
) ();

  logic             OEn;
  logic             CLRn;
  logic             SE;
  logic             LE;
  logic [1:0]       MODE;
  logic             SER_L;
  logic             SER_H;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             QH;
  logic             QA;
  logic [CW-1:0]    CNT;
  logic             FULL;
  logic             LATCHED;

  modport master (
    output OEn, CLRn, SE, LE, MODE,
    output SER_L, SER_H, D,
    input  Q, QH, QA, CNT, FULL, LATCHED
  );

  modport slave (
    input  OEn, CLRn, SE, LE, MODE,
    input  SER_L, SER_H, D,
    output Q, QH, QA, CNT, FULL, LATCHED
  );

endinterface

// File: rtl/shift_storage_reg_counter.sv
// shift_bit_counter: saturating 0..WIDTH count of shifted bits.
// Ports: clk, rst_n, i_clr (force 0), i_rebase (count from 0 this edge),
// i_inc, i_set_max, o_cnt, o_full (==WIDTH), o_last (==WIDTH-1).
module shift_bit_counter
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_rebase,
  input  logic          i_inc,
  input  logic          i_set_max,
  output logic [CW-1:0] o_cnt,
  output logic          o_full,
  output logic          o_last
);

  localparam logic [CW-1:0] C_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_next;

  // A manual latch restarts the count, but a shift on the
  // same edge still counts on top of the restarted value.
  always_comb begin
    w_base = i_rebase ? '0 : r_cnt;
    w_next = w_base;
    if (i_clr)
      w_next = '0;
    else if (i_set_max)
      w_next = C_MAX;
    else if (i_inc)
      w_next = (w_base == C_MAX) ? C_MAX : w_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else
      r_cnt <= w_next;
  end

  assign o_cnt  = r_cnt;
  assign o_full = (r_cnt == C_MAX);
  assign o_last = (r_cnt == C_LAST);

endmodule

// File: rtl/shift_storage_reg.sv
// shift_storage_reg: WIDTH-bit bidirectional shift register with
// parallel load, storage latch, shifted-bit counter and LATCHED pulse.
// Ports: CLK, RSTn (async, active-low), bus (slave side of
// shift_storage_reg_if: controls in, Q/QH/QA/CNT/FULL/LATCHED out).
module shift_storage_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit AUTO_LATCH = 1'b0
) (
  input  logic                CLK,
  input  logic                RSTn,
  shift_storage_reg_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_store;
  logic             r_latched;

  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_up;
  logic             w_dn;
  logic             w_ld;
  logic             w_shift;
  logic             w_last;
  logic             w_auto;
  logic [CW-1:0]    w_cnt;
  logic             w_full;

  // CLRn takes priority, so every move is qualified by it;
  // this keeps the cases below mutually exclusive.
  assign w_up    = bus.CLRn & bus.SE & (bus.MODE == MODE_UP);
  assign w_dn    = bus.CLRn & bus.SE & (bus.MODE == MODE_DOWN);
  assign w_ld    = bus.CLRn & bus.SE & (bus.MODE == MODE_LOAD);
  assign w_shift = w_up | w_dn;

  // Auto latch fires on the shift that would bring CNT to WIDTH.
  assign w_auto  = AUTO_LATCH & w_shift & w_last;

  always_comb begin
    w_shift_nxt = r_shift;
    unique case (1'b1)
      !bus.CLRn: w_shift_nxt = '0;
      w_up:      w_shift_nxt = {r_shift[WIDTH-2:0], bus.SER_L};
      w_dn:      w_shift_nxt = {bus.SER_H, r_shift[WIDTH-1:1]};
      w_ld:      w_shift_nxt = bus.D;
      default:   w_shift_nxt = r_shift;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      r_shift <= '0;
    else
      r_shift <= w_shift_nxt;
  end

  // Auto latch captures the post-shift word; a manual latch
  // captures the pre-edge word, one stage behind the shifter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      r_store <= '0;
    else if (w_auto)
      r_store <= w_shift_nxt;
    else if (bus.LE)
      r_store <= r_shift;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      r_latched <= 1'b0;
    else
      r_latched <= w_auto | bus.LE;
  end

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk       (CLK),
    .rst_n     (RSTn),
    .i_clr     (~bus.CLRn | w_auto),
    .i_rebase  (bus.LE),
    .i_inc     (w_shift & ~w_auto),
    .i_set_max (w_ld),
    .o_cnt     (w_cnt),
    .o_full    (w_full),
    .o_last    (w_last)
  );

  assign bus.Q       = bus.OEn ? '0 : r_store;
  assign bus.QH      = r_shift[WIDTH-1];
  assign bus.QA      = r_shift[0];
  assign bus.CNT     = w_cnt;
  assign bus.FULL    = w_full;
  assign bus.LATCHED = r_latched;

endmodule

// File: tb/tb_shift_storage_reg.sv
// Directed bench: an 8-bit manual-latch instance and a 16-bit
// auto-latch instance sharing one clock and reset.
module tb_shift_storage_reg;
  import shift_reg_pkg::*;

  logic CLK = 1'b0;
  logic RSTn;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [7:0]  old8;
  logic [7:0]  pat8;
  logic [11:0] pat12;
  logic [15:0] pat16;

  shift_storage_reg_if #(.WIDTH(8))  a_if ();
  shift_storage_reg_if #(.WIDTH(16)) b_if ();

  shift_storage_reg #(
    .WIDTH      (8),
    .AUTO_LATCH (1'b0)
  ) u_a (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (a_if.slave)
  );

  shift_storage_reg #(
    .WIDTH      (16),
    .AUTO_LATCH (1'b1)
  ) u_b (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (b_if.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_up(input logic b);
    a_if.SE    = 1'b1;
    a_if.MODE  = MODE_UP;
    a_if.SER_L = b;
    tick();
    a_if.SE    = 1'b0;
  endtask

  task automatic a_dn(input logic b);
    a_if.SE    = 1'b1;
    a_if.MODE  = MODE_DOWN;
    a_if.SER_H = b;
    tick();
    a_if.SE    = 1'b0;
  endtask

  task automatic b_up(input logic b);
    b_if.SE    = 1'b1;
    b_if.MODE  = MODE_UP;
    b_if.SER_L = b;
    tick();
    b_if.SE    = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0;
    a_if.OEn = 1'b0; a_if.CLRn = 1'b1; a_if.SE = 1'b0;
    a_if.LE = 1'b0; a_if.MODE = MODE_HOLD;
    a_if.SER_L = 1'b0; a_if.SER_H = 1'b0; a_if.D = '0;
    b_if.OEn = 1'b0; b_if.CLRn = 1'b1; b_if.SE = 1'b0;
    b_if.LE = 1'b0; b_if.MODE = MODE_HOLD;
    b_if.SER_L = 1'b0; b_if.SER_H = 1'b0; b_if.D = '0;
    #2;
    chk("rst_q",    a_if.Q,       32'h0);
    chk("rst_cnt",  a_if.CNT,     32'h0);
    chk("rst_full", a_if.FULL,    32'h0);
    chk("rst_lat",  a_if.LATCHED, 32'h0);
    chk("rst_qh",   a_if.QH,      32'h0);
    chk("rst_b_q",  b_if.Q,       32'h0);
    tick();
    RSTn = 1'b1;
    tick();

    // shift up 0xA5 MSB-first, then manual latch
    pat8 = 8'hA5;
    for (int i = 7; i >= 0; i--) a_up(pat8[i]);
    chk("up_cnt",  a_if.CNT,  32'd8);
    chk("up_full", a_if.FULL, 32'h1);
    chk("up_q_pre", a_if.Q,   32'h0);
    a_if.LE = 1'b1;
    tick();
    a_if.LE = 1'b0;
    chk("up_q",   a_if.Q,       32'hA5);
    chk("up_cnt0", a_if.CNT,    32'h0);
    chk("up_lat", a_if.LATCHED, 32'h1);
    tick();
    chk("up_lat0", a_if.LATCHED, 32'h0);
    a_if.OEn = 1'b1;
    #1;
    chk("oen_q", a_if.Q, 32'h0);
    a_if.OEn = 1'b0;
    #1;
    chk("oen_q_back", a_if.Q, 32'hA5);

    // shift down 0x3C LSB-first; QA streams the old word out
    old8 = 8'hA5;
    pat8 = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      chk("qa_stream", a_if.QA, 32'(old8[i]));
      a_dn(pat8[i]);
    end
    a_if.LE = 1'b1;
    tick();
    a_if.LE = 1'b0;
    chk("dn_q", a_if.Q, 32'h3C);

    // parallel load with simultaneous latch
    a_if.D = 8'h5A; a_if.SE = 1'b1;
    a_if.MODE = MODE_LOAD; a_if.LE = 1'b1;
    tick();
    a_if.SE = 1'b0;
    chk("ld_q_old", a_if.Q,       32'h3C);
    chk("ld_cnt",   a_if.CNT,     32'd8);
    chk("ld_full",  a_if.FULL,    32'h1);
    chk("ld_lat",   a_if.LATCHED, 32'h1);
    tick();
    a_if.LE = 1'b0;
    chk("ld_q_new", a_if.Q,       32'h5A);
    chk("ld_cnt0",  a_if.CNT,     32'h0);
    chk("ld_lat2",  a_if.LATCHED, 32'h1);
    tick();
    chk("ld_lat0",  a_if.LATCHED, 32'h0);

    // clear mid-stream beats a concurrent shift
    for (int i = 0; i < 5; i++) a_up(1'b1);
    chk("clr_cnt5", a_if.CNT, 32'd5);
    chk("clr_qa1",  a_if.QA,  32'h1);
    a_if.CLRn = 1'b0; a_if.SE = 1'b1;
    a_if.MODE = MODE_UP; a_if.SER_L = 1'b1;
    tick();
    a_if.CLRn = 1'b1; a_if.SE = 1'b0;
    chk("clr_cnt", a_if.CNT, 32'h0);
    chk("clr_qa",  a_if.QA,  32'h0);
    chk("clr_q",   a_if.Q,   32'h5A);

    // saturation and cascade out of QH
    pat12 = 12'hC35;
    for (int k = 1; k <= 12; k++) begin
      a_up(pat12[12-k]);
      if (k >= 8 && k <= 11)
        chk("qh_cascade", a_if.QH, 32'(pat12[19-k]));
    end
    chk("sat_cnt",  a_if.CNT,  32'd8);
    chk("sat_full", a_if.FULL, 32'h1);
    a_if.LE = 1'b1;
    tick();
    chk("sat_q",    a_if.Q,   32'h35);
    chk("sat_cnt0", a_if.CNT, 32'h0);
    a_if.SE = 1'b1; a_if.MODE = MODE_UP; a_if.SER_L = 1'b1;
    tick();
    a_if.SE = 1'b0;
    chk("le_sh_cnt", a_if.CNT, 32'h1);
    chk("le_sh_q",   a_if.Q,   32'h35);
    a_if.CLRn = 1'b0;
    tick();
    a_if.CLRn = 1'b1; a_if.LE = 1'b0;
    chk("le_clr_q",   a_if.Q,   32'h6B);
    chk("le_clr_cnt", a_if.CNT, 32'h0);
    chk("le_clr_qh",  a_if.QH,  32'h0);

    // auto latch, 16 bits
    pat16 = 16'hBEEF;
    for (int k = 1; k <= 16; k++) begin
      b_up(pat16[16-k]);
      if (k == 15) begin
        chk("au_cnt15", b_if.CNT,     32'd15);
        chk("au_q_pre", b_if.Q,       32'h0);
        chk("au_lat_p", b_if.LATCHED, 32'h0);
      end
    end
    chk("au_q",    b_if.Q,       32'hBEEF);
    chk("au_cnt",  b_if.CNT,     32'h0);
    chk("au_full", b_if.FULL,    32'h0);
    chk("au_lat",  b_if.LATCHED, 32'h1);
    tick();
    chk("au_lat0", b_if.LATCHED, 32'h0);
    pat16 = 16'h1234;
    for (int k = 1; k <= 16; k++) begin
      b_if.LE = (k == 16);
      b_up(pat16[16-k]);
    end
    b_if.LE = 1'b0;
    chk("au2_q",   b_if.Q,       32'h1234);
    chk("au2_cnt", b_if.CNT,     32'h0);
    chk("au2_lat", b_if.LATCHED, 32'h1);
    tick();
    chk("au2_lat0", b_if.LATCHED, 32'h0);
    b_if.D = 16'hFFFF; b_if.SE = 1'b1; b_if.MODE = MODE_LOAD;
    tick();
    b_if.SE = 1'b0;
    chk("au_ld_cnt",  b_if.CNT,     32'd16);
    chk("au_ld_full", b_if.FULL,    32'h1);
    chk("au_ld_lat",  b_if.LATCHED, 32'h0);
    chk("au_ld_q",    b_if.Q,       32'h1234);

    // asynchronous reset mid-cycle
    #2;
    RSTn = 1'b0;
    #1;
    chk("ar_a_q",    a_if.Q,    32'h0);
    chk("ar_b_q",    b_if.Q,    32'h0);
    chk("ar_b_cnt",  b_if.CNT,  32'h0);
    chk("ar_b_full", b_if.FULL, 32'h0);
    chk("ar_b_qh",   b_if.QH,   32'h0);
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
    a_up(1'b1);
    chk("ar_post_qa",  a_if.QA,  32'h1);
    chk("ar_post_cnt", a_if.CNT, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_storage_reg.md
Name: shift_storage_reg

Overview:
- Parametrised successor to the 8-bit serial-in/parallel-out shift-plus-storage register model.
- Generalised to WIDTH bits on one clock; the separate shift/storage clocks become enable strobes.
- Adds bidirectional shift, parallel load, a shifted-bit counter with FULL flag, optional auto-latch, and a LATCHED pulse.
- Used in testbenches and chip models wherever a cascaded or wider 595-class expander is needed.

Parameters:
- WIDTH, 8: shift and storage register width; legal values ≥ 2.
- AUTO_LATCH, 0: if 1, storage loads automatically when the WIDTH-th bit is shifted in.
- CW, $clog2(WIDTH+1): counter width (derived; not overridden).

Ports:
- CLK  input  1  single clock; all state changes on its rising edge.
- RSTn  input  1  reset; asynchronous, active-low.
- OEn  input  1  output enable, active-low; gates Q only.
- CLRn  input  1  synchronous clear of the shift register and counter, active-low.
- SE  input  1  shift/load enable; qualifies MODE.
- LE  input  1  storage latch strobe.
- MODE  input  2  00 hold, 01 shift up (toward MSB), 10 shift down (toward LSB), 11 parallel load.
- SER_L  input  1  serial input entering bit 0 on shift up.
- SER_H  input  1  serial input entering bit WIDTH-1 on shift down.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  storage register when OEn=0, else all zeros.
- QH  output  1  shift_reg[WIDTH-1]; cascade out for shift up.
- QA  output  1  shift_reg[0]; cascade out for shift down.
- CNT  output  CW  number of bits shifted since the last latch or clear; saturates at WIDTH.
- FULL  output  1  CNT == WIDTH.
- LATCHED  output  1  one-cycle pulse in the cycle after storage updates.

Behaviour:
- Reset (RSTn=0, asynchronous):
  - shift_reg, storage_reg, CNT and LATCHED go to 0.
  - Q, QH, QA and FULL are therefore 0.
  - Reset mid-shift discards all partial data; the first edge after release behaves as a normal cycle.
- Shift register priority, per edge:
  1. CLRn=0: shift_reg=0, CNT=0, regardless of SE and MODE.
  2. SE=1, MODE=01: shift_reg={shift_reg[W-2:0],SER_L}, CNT+1 (saturating).
  3. SE=1, MODE=10: shift_reg={SER_H,shift_reg[W-1:1]}, CNT+1 (saturating).
  4. SE=1, MODE=11: shift_reg=D, CNT=WIDTH.
  5. Otherwise (SE=0 or MODE=00): hold.
- Manual latch:
  - LE=1: storage_reg takes the pre-edge shift_reg value. This matches the tied-clock 595 behaviour, where storage lags shift by one stage.
  - LE with a simultaneous shift: storage gets the old value, and CNT becomes 1 (0 after latch, plus the concurrent shift).
  - LE with a simultaneous CLRn=0: storage gets the pre-clear value; CNT=0.
  - LE alone: CNT=0.
- Auto latch (AUTO_LATCH=1 only):
  - Trigger: a shift edge on which CNT goes from WIDTH-1 to WIDTH.
  - Storage takes the post-shift value on that same edge, and CNT is set to 0 instead of WIDTH. FULL therefore never stays high from shifting.
  - Parallel load does not trigger auto latch.
  - LE on the trigger edge: auto latch wins (storage gets the post-shift value); a single LATCHED pulse results.
  - CLRn=0 suppresses auto latch.
- LATCHED: registered; high for exactly one cycle after any storage update (manual or auto). Back-to-back LE gives a continuous high.
- CNT saturation: with AUTO_LATCH=0, shifting past WIDTH holds CNT at WIDTH, and the oldest bits fall out via QH or QA.
- Q is combinational from OEn and storage_reg. OEn never affects internal state.
- Latency:
  - Serial bit to Q: WIDTH shift edges plus one LE edge (manual), or WIDTH shift edges (auto).
  - Storage update to LATCHED: 1 cycle.

Decomposition:
- Shared package shift_reg_pkg:
  - MODE constants MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11.
  - Function for the counter width.
- Sub-module shift_bit_counter (parameter WIDTH): saturating counter with clear, increment and set-to-max inputs, plus a reached-(WIDTH-1) output used for the auto-latch trigger.
- The top level holds the shift register, storage register and LATCHED flop.

Test Plan:
- WIDTH=8, AUTO_LATCH=0:
  - Shift up 0xA5 MSB-first via SER_L (8 edges), then LE → Q=0xA5, CNT 8→0, LATCHED high 1 cycle. With OEn=1 → Q=0x00.
  - Shift down 0x3C LSB-first via SER_H, then LE → Q=0x3C; QA streams the old contents during the shift.
  - Parallel load D=0x5A with simultaneous LE → Q holds the old value. Next LE alone → Q=0x5A.
  - After the load, CNT=8 and FULL=1.
- WIDTH=16, AUTO_LATCH=1: shift up 0xBEEF → on the 16th edge Q=0xBEEF, CNT=0, one LATCHED pulse; the next 16 bits 0x1234 give Q=0x1234.
- Clear and reset:
  - CLRn=0 with SE=1, MODE=01 mid-stream (CNT=5) → shift_reg=0, CNT=0, Q unchanged.
  - RSTn asserted asynchronously mid-cycle → all outputs 0 immediately.
- Saturation and cascade (AUTO_LATCH=0, WIDTH=8): 12 shift-up edges → CNT stays 8. QH outputs the first 4 bits shifted in, one bit per edge starting at the 9th; then LE gives Q equal to the last 8 bits.
